// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: two-port front end for a single spi_ram_controller.
// Port 0 is the data (load/store) port. Port 1 is the instruction-fetch port.
// Transactions are serialised as IDLE -> ISSUE -> WAIT.
// Optional macro SPI_RAM_ARB_ROUND_ROBIN_EN: when it is defined, ties alternate
// between the ports. When it is undefined, port 0 always wins a tie.
module spi_ram_arbiter #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_BITS-1:0]  p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_grant,
    output logic                  p0_done,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_BITS-1:0]  p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_grant,
    output logic                  p1_done,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_BITS-1:0]  ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_start_read,
    output logic                  ram_start_write,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_busy,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;   // 0 = port 0, 1 = port 1
    logic                  we_q, we_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
`ifdef SPI_RAM_ARB_ROUND_ROBIN_EN
    logic                  rr_last_q, rr_last_d;
`endif

    logic any_req;
    logic winner;       // 1 = port 1 wins this IDLE cycle
    logic accept;       // a request is taken in this IDLE cycle
    logic complete;     // the controller has finished in WAIT

    // Winner selection. A single requester always wins.
    always_comb begin
        any_req = p0_req | p1_req;
`ifdef SPI_RAM_ARB_ROUND_ROBIN_EN
        if (p0_req && p1_req) begin
            winner = ~rr_last_q;
        end else begin
            winner = ~p0_req;
        end
`else
        winner = ~p0_req;
`endif
        accept   = (state_q == ST_IDLE) && any_req;
        complete = (state_q == ST_WAIT) && !ram_busy;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (!ram_busy) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: latch the request on accept, and capture read data on completion.
    always_comb begin
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
`ifdef SPI_RAM_ARB_ROUND_ROBIN_EN
        rr_last_d  = rr_last_q;
`endif
        if (accept) begin
            owner_d = winner;
            we_d    = winner ? p1_we    : p0_we;
            addr_d  = winner ? p1_addr  : p0_addr;
            wdata_d = winner ? p1_wdata : p0_wdata;
`ifdef SPI_RAM_ARB_ROUND_ROBIN_EN
            rr_last_d = winner;
`endif
        end
        if (complete && !we_q) begin
            if (owner_q) begin
                p1_rdata_d = ram_rdata;
            end else begin
                p0_rdata_d = ram_rdata;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
`ifdef SPI_RAM_ARB_ROUND_ROBIN_EN
            rr_last_q  <= 1'b1;
`endif
        end else begin
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
`ifdef SPI_RAM_ARB_ROUND_ROBIN_EN
            rr_last_q  <= rr_last_d;
`endif
        end
    end

    // Outputs: grant and done pulses, start strobes only in ISSUE, and latched address and data.
    always_comb begin
        p0_grant        = accept && !winner;
        p1_grant        = accept &&  winner;
        p0_done         = complete && !owner_q;
        p1_done         = complete &&  owner_q;
        ram_start_read  = (state_q == ST_ISSUE) && !we_q;
        ram_start_write = (state_q == ST_ISSUE) &&  we_q;
        ram_addr        = addr_q;
        ram_wdata       = wdata_q;
        p0_rdata        = p0_rdata_q;
        p1_rdata        = p1_rdata_q;
        busy            = (state_q != ST_IDLE);
    end

endmodule
